alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_arbiter_alu.sv | 43 ++++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the arbitrated ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_GT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: unsigned operands, WIDTH+1 result, error flag on divide/modulus by zero.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   res,
  output logic             err
);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  // Shifts move by one position; shr result is a plain logical shift of a.
  always_comb begin
    res = '0;
    err = 1'b0;
    case (sel)
      OP_PASS: res = a_x;
      OP_ADD:  res = a_x + b_x;
      OP_SUB:  res = a_x - b_x;
      OP_DIV: begin
        if (b == '0) err = 1'b1;
        else         res = {1'b0, a / b};
      end
      OP_MOD: begin
        if (b == '0) err = 1'b1;
        else         res = {1'b0, a % b};
      end
      OP_SHL:  res = {a, 1'b0};
      OP_SHR:  res = {2'b00, a[WIDTH-1:1]};
      OP_GT:   res = {{WIDTH{1'b0}}, (a > b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; one command in flight, IDLE->EXEC->RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_data,
  output logic             rsp_err
);

  state_t           state;
  logic             last_grant;
  logic [2:0]       sel_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             id_p0;
  logic             gnt_any;
  logic             gnt_id;
  logic             idle;
  logic [WIDTH:0]   alu_res;
  logic             alu_err;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = req1_valid;
  end

  assign idle       = rst_n && (state == ST_IDLE);
  assign req0_ready = idle && gnt_any && !gnt_id;
  assign req1_ready = idle && gnt_id;

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .sel (sel_p0),
    .a   (a_p0),
    .b   (b_p0),
    .res (alu_res),
    .err (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      sel_p0     <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      id_p0      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        // p0: capture the granted command
        ST_IDLE: begin
          if (gnt_any) begin
            sel_p0     <= gnt_id ? req1_sel : req0_sel;
            a_p0       <= gnt_id ? req1_a   : req0_a;
            b_p0       <= gnt_id ? req1_b   : req0_b;
            id_p0      <= gnt_id;
            last_grant <= gnt_id;
            state      <= ST_EXEC;
          end
        end
        // p1: register ALU result into the response
        ST_EXEC: begin
          rsp_data  <= alu_res;
          rsp_err   <= alu_err;
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic.
module tb_alu_arbiter;

  localparam int W = 8;
  localparam int unsigned MODV = 1 << (W + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_sel, req1_sel;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W:0]   rsp_data;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  typedef struct {
    logic       id;
    logic [W:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb[$];
  exp_t rlog[$];
  int   glog[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic last_m = 1'b1;
  bit   idle_m = 1'b1;
  bit   acc0_f = 1'b0, acc1_f = 1'b0;
  bit   gap_off = 1'b1, perturb = 1'b0, rdy_rand = 1'b0, rdy_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: operands as plain unsigned integers, results reduced mod 2^(W+1).
  function automatic void model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W:0] d, output logic e);
    int unsigned av, bv, r;
    av = a; bv = b; r = 0; e = 1'b0;
    case (s)
      3'd0: r = av;
      3'd1: r = av + bv;
      3'd2: r = (av + MODV - bv) % MODV;
      3'd3: if (bv == 0) e = 1'b1; else r = av / bv;
      3'd4: if (bv == 0) e = 1'b1; else r = av % bv;
      3'd5: r = (av * 2) % MODV;
      3'd6: r = av / 2;
      default: r = (av > bv) ? 1 : 0;
    endcase
    d = r[W:0];
  endfunction

  function automatic cmd_t mk(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    cmd_t c;
    c.sel = s; c.a = a; c.b = b;
    return c;
  endfunction

  // Driver: presents queued commands, holds until accepted, drives rsp_ready.
  initial begin : drv
    cmd_t c;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_sel = 0; req0_a = 0; req0_b = 0;
    req1_sel = 0; req1_a = 0; req1_b = 0;
    forever begin
      @(posedge clk); #1;
      if (acc0_f) req0_valid = 0;
      if (acc1_f) req1_valid = 0;
      if (!req0_valid && q0.size() > 0 && (gap_off || $urandom_range(0, 2) != 0)) begin
        c = q0.pop_front();
        req0_sel = c.sel; req0_a = c.a; req0_b = c.b; req0_valid = 1;
      end else if (req0_valid && perturb && $urandom_range(0, 15) == 0) begin
        req0_valid = 0;
      end else if (req0_valid && perturb && $urandom_range(0, 7) == 0) begin
        req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
      if (!req1_valid && q1.size() > 0 && (gap_off || $urandom_range(0, 2) != 0)) begin
        c = q1.pop_front();
        req1_sel = c.sel; req1_a = c.a; req1_b = c.b; req1_valid = 1;
      end else if (req1_valid && perturb && $urandom_range(0, 15) == 0) begin
        req1_valid = 0;
      end else if (req1_valid && perturb && $urandom_range(0, 7) == 0) begin
        req1_a = 8'($urandom); req1_b = 8'($urandom);
      end
      rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
    end
  end

  // Monitor: grant prediction on accept, response compare/pop, hold and reset checks.
  logic       a0, a1, pv, pr, pid, perr, eg;
  logic [W:0] pdata;
  exp_t       e;
  initial begin : mon
    pv = 0; pr = 0; pid = 0; perr = 0; pdata = '0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      acc0_f = a0; acc1_f = a1;
      if (!rst_n) begin
        check("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'd0);
        sb.delete(); idle_m = 1; last_m = 1; pv = 0;
        continue;
      end
      if (rsp_valid) check("ready_in_resp", 32'({req0_ready, req1_ready}), 32'd0);
      if (idle_m && (req0_valid || req1_valid)) begin
        eg = (req0_valid && req1_valid) ? ~last_m : req1_valid;
        check("grant", 32'({a1, a0}), eg ? 32'd2 : 32'd1);
        if (a0 || a1) begin
          e.id = a1;
          if (a1) model(req1_sel, req1_a, req1_b, e.data, e.err);
          else    model(req0_sel, req0_a, req0_b, e.data, e.err);
          e.cyc = cyc + 2;
          sb.push_back(e); glog.push_back(int'(a1));
          last_m = a1; idle_m = 0;
        end
      end else if (a0 || a1) begin
        check("accept_while_busy", 32'({a1, a0}), 32'd0);
      end
      if (rsp_valid && pv && !pr)
        check("hold_stable", 32'({rsp_id, rsp_err, rsp_data}), 32'({pid, perr, pdata}));
      if (rsp_valid && !pv) begin
        if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          check("rsp_latency", 32'(cyc), 32'(sb[0].cyc));
          check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          e.id = rsp_id; e.data = rsp_data; e.err = rsp_err; e.cyc = cyc;
          rlog.push_back(e);
        end
      end else if (!rsp_valid && sb.size() > 0 && cyc > sb[0].cyc) begin
        check("rsp_missing", 32'(rsp_valid), 32'd1);
        void'(sb.pop_front()); idle_m = 1;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        idle_m = 1;
      end
      pv = rsp_valid; pr = rsp_ready; pid = rsp_id; perr = rsp_err; pdata = rsp_data;
    end
  end

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || sb.size() > 0 || !idle_m)
           && t < 3000) begin
      @(negedge clk); t++;
    end
    check({"drain_", nm}, 32'(t < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_flag(input string nm, input bit want_acc);
    int t;
    t = 0;
    while (!(want_acc ? acc0_f : rsp_valid) && t < 100) begin
      @(negedge clk); t++;
    end
    check({"wait_", nm}, 32'(t < 100), 32'd1);
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);

    // Tie right after reset: requester 0 first, then 1.
    q0.push_back(mk(3'd2, 8'd5, 8'd3));
    q1.push_back(mk(3'd5, 8'h81, 8'd1));
    drain("tie");
    check("tie_n", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2) begin
      check("tie_first_id", 32'(rlog[0].id), 32'd0);
      check("tie_first_data", 32'(rlog[0].data), 32'h002);
      check("tie_second_id", 32'(rlog[1].id), 32'd1);
      check("tie_second_data", 32'(rlog[1].data), 32'h102);
    end

    rlog.delete();
    q0.push_back(mk(3'd1, 8'd200, 8'd100));
    drain("add");
    check("add_n", 32'(rlog.size()), 32'd1);
    if (rlog.size() == 1)
      check("add_result", 32'({rlog[0].id, rlog[0].err, rlog[0].data}), 32'h012C);

    rlog.delete();
    q1.push_back(mk(3'd3, 8'd9, 8'd0));
    q1.push_back(mk(3'd4, 8'd9, 8'd4));
    drain("divmod");
    check("divmod_n", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2) begin
      check("div0_result", 32'({rlog[0].err, rlog[0].data}), 32'h200);
      check("mod_result", 32'({rlog[1].err, rlog[1].data}), 32'h001);
    end

    glog.delete();
    repeat (2) begin
      q0.push_back(mk(3'd0, 8'd7, 8'd0));
      q1.push_back(mk(3'd7, 8'd9, 8'd2));
    end
    drain("rr");
    check("rr_n", 32'(glog.size()), 32'd4);
    if (glog.size() == 4)
      check("rr_order", 32'({glog[0][0], glog[1][0], glog[2][0], glog[3][0]}), 32'b0101);

    // Consumer stall with a second command waiting.
    rdy_force = 0;
    q0.push_back(mk(3'd6, 8'hF1, 8'd0));
    wait_flag("stall_rsp", 1'b0);
    q1.push_back(mk(3'd1, 8'hFF, 8'hFF));
    repeat (5) @(negedge clk);
    check("stall_valid", 32'(rsp_valid), 32'd1);
    rdy_force = 1;
    drain("stall");

    // Reset while the accepted command sits in EXEC.
    q0.push_back(mk(3'd1, 8'd1, 8'd2));
    wait_flag("rst_acc", 1'b1);
    @(posedge clk); #2;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (4) @(negedge clk);
    rlog.delete();
    q0.push_back(mk(3'd1, 8'd40, 8'd2));
    drain("after_rst");
    check("after_rst_n", 32'(rlog.size()), 32'd1);
    if (rlog.size() == 1)
      check("after_rst_result", 32'({rlog[0].id, rlog[0].data}), 32'h02A);

    // Randomized traffic with gaps, withdrawals, operand churn and consumer back-pressure.
    gap_off = 0; perturb = 1; rdy_rand = 1;
    for (int i = 0; i < 200; i++) begin
      cmd_t c;
      c = mk(3'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
      if ($urandom_range(0, 1) == 0) q0.push_back(c);
      else                           q1.push_back(c);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
